bird_sprite: RTL
================

Name: bird_sprite

Overview:
- Parametrised, stateful successor to the static-square painter: draws one axis-aligned rectangular object (the bird) over a solid background.
- Owns the object's vertical physics: gravity, flap impulse, ceiling clamp and ground collision, updated once per frame.
- Sits between the video timing generator (supplies sx/sy and frame_start) and the pixel output mux.
- Exposes game state for higher-level control logic.

Parameters:
- COORD_W, 16, width of sx/sy/obj_y.
- VEL_W, 8, signed velocity width.
- SCR_H, 480, visible lines; ground line is SCR_H-OBJ_H.
- OBJ_X, 200, fixed left edge of object.
- OBJ_W, 34, object width in pixels.
- OBJ_H, 24, object height in pixels.
- Y_INIT, 228, object top in IDLE and after reset.
- GRAVITY, 1, per-frame velocity increment (positive = downward).
- FLAP_VEL, -8, signed velocity loaded on flap.
- VMAX, 10, maximum downward velocity.
- FG_RGB, 24'hFFD040, object colour, IDLE/FLY.
- DEAD_RGB, 24'hC02020, object colour, DEAD.
- BG_RGB, 24'h103070, background colour.

Ports:
- pix_clk  in  1  pixel clock.
- pix_rst  in  1  synchronous active-high reset.
- sx  in  COORD_W  current pixel x.
- sy  in  COORD_W  current pixel y.
- frame_start  in  1  one-cycle pulse, once per frame, during vertical blank.
- flap  in  1  one-cycle pulse, already synchronised and debounced.
- restart  in  1  one-cycle pulse: return from DEAD to IDLE.
- pause  in  1  level; freezes physics while high.
- obj_y  out  COORD_W  current object top (registered).
- state  out  2  00 IDLE, 01 FLY, 10 DEAD.
- in_obj  out  1  registered: current pixel lies inside the object.
- paint_r  out  8  red channel.
- paint_g  out  8  green channel.
- paint_b  out  8  blue channel.

Behaviour:
- Reset (pix_rst sampled high on a pix_clk edge):
  - obj_y=Y_INIT, vel=0, flap_pend=0, state=IDLE.
  - in_obj=0; paint = BG_RGB.
  - Reset mid-frame or mid-flight discards all motion immediately.
- Flap latch:
  - flap sets flap_pend; flap_pend is cleared when consumed by a physics update.
  - flap coinciding with frame_start is consumed in that same update.
- State machine:
  - IDLE: obj_y and vel held at Y_INIT/0. flap -> FLY with flap_pend=1.
  - FLY: on frame_start with pause=0, apply the physics update below.
  - DEAD: obj_y and vel frozen; flap ignored and flap_pend cleared. restart -> IDLE (obj_y=Y_INIT, vel=0).
  - restart in IDLE or FLY has no effect.
- Physics update (FLY, frame_start, pause=0), all in one cycle:
  - nv = FLAP_VEL if flap_pend, else min(vel+GRAVITY, VMAX).
  - ny = obj_y + nv, computed signed at COORD_W+1 bits.
  - If ny <= 0: obj_y=0, vel=0 (ceiling clamp, not fatal).
  - Else if ny >= SCR_H-OBJ_H: obj_y=SCR_H-OBJ_H, vel=0, state=DEAD.
  - Otherwise: obj_y=ny, vel=nv.
  - New values are visible on outputs the cycle after frame_start.
- pause:
  - frame_start is ignored while pause is high.
  - flap still latches in FLY and is held until the next unpaused update.
- Pixel path:
  - Hit = OBJ_X <= sx <= OBJ_X+OBJ_W-1 and obj_y <= sy <= obj_y+OBJ_H-1 (inclusive bounds).
  - in_obj and paint_* are registered: latency 1 cycle from sx/sy.
  - Colour: hit -> DEAD_RGB in DEAD, FG_RGB otherwise; no hit -> BG_RGB.
  - Channel mapping: R=[23:16], G=[15:8], B=[7:0].

Test Plan:
- Reset: assert pix_rst 2 cycles, release -> state=IDLE, obj_y=228, paint=10/30/70 for any sx/sy.
- Fall to ground: one flap then no input. Frame 1 -> obj_y=220 (vel -8), frame 2 -> 213. Count frames until state=DEAD with obj_y=456; check against a reference model. No further motion on extra frame_start pulses.
- Simultaneous events: flap and frame_start in the same cycle in FLY at obj_y=300, vel=5 -> obj_y=292 next cycle, flap_pend=0.
- Ceiling: repeated flap every frame from obj_y=10 -> obj_y clamps to 0 with vel=0; state stays FLY.
- Pause, restart, reset mid-flight:
  - pause high across 3 frame_start pulses -> obj_y unchanged.
  - flap during pause -> applied on the first unpaused frame.
  - restart in DEAD -> IDLE, obj_y=228.
  - pix_rst in FLY -> IDLE, obj_y=228.
- Pixel edges at obj_y=228:
  - sx=199/200/233/234 with sy=240 -> in_obj 0/1/1/0.
  - sy=227/228/251/252 with sx=210 -> in_obj 0/1/1/0.
  - All responses appear exactly one cycle after sx/sy are applied.
  - In DEAD, inside pixels paint C0/20/20.

Source files
------------

// File: rtl/bird_sprite.sv
`default_nettype none
// ============================================================================
// Module      : bird_sprite
// Description : One rectangular sprite with per-frame vertical physics
//               (gravity, flap, ceiling clamp, ground death) and a
//               registered pixel painter.
// Revision    : 1.0 - initial release
// ============================================================================
module bird_sprite #(
    parameter int          COORD_W  = 16,
    parameter int          VEL_W    = 8,
    parameter int          SCR_H    = 480,
    parameter int          OBJ_X    = 200,
    parameter int          OBJ_W    = 34,
    parameter int          OBJ_H    = 24,
    parameter int          Y_INIT   = 228,
    parameter int          GRAVITY  = 1,
    parameter int          FLAP_VEL = -8,
    parameter int          VMAX     = 10,
    parameter logic [23:0] FG_RGB   = 24'hFFD040,
    parameter logic [23:0] DEAD_RGB = 24'hC02020,
    parameter logic [23:0] BG_RGB   = 24'h103070
) (
    input  logic               pix_clk,
    input  logic               pix_rst,
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    input  logic               frame_start,
    input  logic               flap,
    input  logic               restart,
    input  logic               pause,
    output logic [COORD_W-1:0] obj_y,
    output logic [1:0]         state,
    output logic               in_obj,
    output logic [7:0]         paint_r,
    output logic [7:0]         paint_g,
    output logic [7:0]         paint_b
);

    localparam logic [1:0] c_st_idle = 2'b00;
    localparam logic [1:0] c_st_fly  = 2'b01;
    localparam logic [1:0] c_st_dead = 2'b10;

    localparam logic        [COORD_W-1:0] c_y_init   = COORD_W'(Y_INIT);
    localparam logic signed [COORD_W:0]   c_ground   = (COORD_W+1)'(SCR_H - OBJ_H);
    localparam logic signed [VEL_W-1:0]   c_flap_vel = VEL_W'(FLAP_VEL);
    localparam logic signed [VEL_W:0]     c_gravity  = (VEL_W+1)'(GRAVITY);
    localparam logic signed [VEL_W:0]     c_vmax     = (VEL_W+1)'(VMAX);
    localparam logic        [COORD_W-1:0] c_x_lo     = COORD_W'(OBJ_X);
    localparam logic        [COORD_W-1:0] c_x_hi     = COORD_W'(OBJ_X + OBJ_W - 1);
    localparam logic        [COORD_W:0]   c_h_m1     = (COORD_W+1)'(OBJ_H - 1);

    logic [1:0]                state_q,     state_d;
    logic [COORD_W-1:0]        obj_y_q,     obj_y_d;
    logic signed [VEL_W-1:0]   vel_q,       vel_d;
    logic                      flap_pend_q, flap_pend_d;
    logic                      in_obj_q,    in_obj_d;
    logic [23:0]               rgb_q,       rgb_d;

    logic                      w_pend_eff;
    logic signed [VEL_W:0]     w_vel_inc;
    logic signed [VEL_W-1:0]   w_nv;
    logic signed [COORD_W:0]   w_ny;
    logic                      w_hit_ceiling;
    logic                      w_x_hit;
    logic                      w_y_hit;

    // State register
    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            state_q     <= c_st_idle;
            obj_y_q     <= c_y_init;
            vel_q       <= '0;
            flap_pend_q <= 1'b0;
            in_obj_q    <= 1'b0;
            rgb_q       <= BG_RGB;
        end else begin
            state_q     <= state_d;
            obj_y_q     <= obj_y_d;
            vel_q       <= vel_d;
            flap_pend_q <= flap_pend_d;
            in_obj_q    <= in_obj_d;
            rgb_q       <= rgb_d;
        end
    end

    // A flap arriving in the same cycle as the update is consumed by it.
    always_comb begin
        w_pend_eff = flap_pend_q | flap;
        w_vel_inc  = $signed({vel_q[VEL_W-1], vel_q}) + c_gravity;
        if (w_pend_eff) begin
            w_nv = c_flap_vel;
        end else if (w_vel_inc > c_vmax) begin
            w_nv = c_vmax[VEL_W-1:0];
        end else begin
            w_nv = w_vel_inc[VEL_W-1:0];
        end
        w_ny          = $signed({1'b0, obj_y_q}) + (COORD_W+1)'(w_nv);
        w_hit_ceiling = w_ny[COORD_W] | ~|w_ny;
    end

    // Next-state and physics
    always_comb begin
        state_d     = state_q;
        obj_y_d     = obj_y_q;
        vel_d       = vel_q;
        flap_pend_d = flap_pend_q;
        case (state_q)
            c_st_idle: begin
                obj_y_d = c_y_init;
                vel_d   = '0;
                if (flap) begin
                    state_d     = c_st_fly;
                    flap_pend_d = 1'b1;
                end
            end
            c_st_fly: begin
                if (flap) begin
                    flap_pend_d = 1'b1;
                end
                if (frame_start && !pause) begin
                    flap_pend_d = 1'b0;
                    if (w_hit_ceiling) begin
                        obj_y_d = '0;
                        vel_d   = '0;
                    end else if (w_ny >= c_ground) begin
                        obj_y_d = c_ground[COORD_W-1:0];
                        vel_d   = '0;
                        state_d = c_st_dead;
                    end else begin
                        obj_y_d = w_ny[COORD_W-1:0];
                        vel_d   = w_nv;
                    end
                end
            end
            c_st_dead: begin
                flap_pend_d = 1'b0;
                if (restart) begin
                    state_d = c_st_idle;
                    obj_y_d = c_y_init;
                    vel_d   = '0;
                end
            end
            default: begin
                state_d     = c_st_idle;
                obj_y_d     = c_y_init;
                vel_d       = '0;
                flap_pend_d = 1'b0;
            end
        endcase
    end

    // Pixel path; the y bound is widened so obj_y+OBJ_H-1 cannot wrap.
    always_comb begin
        w_x_hit  = (sx >= c_x_lo) && (sx <= c_x_hi);
        w_y_hit  = ({1'b0, sy} >= {1'b0, obj_y_q}) &&
                   ({1'b0, sy} <= ({1'b0, obj_y_q} + c_h_m1));
        in_obj_d = w_x_hit && w_y_hit;
        if (!in_obj_d) begin
            rgb_d = BG_RGB;
        end else if (state_q == c_st_dead) begin
            rgb_d = DEAD_RGB;
        end else begin
            rgb_d = FG_RGB;
        end
    end

    assign obj_y   = obj_y_q;
    assign state   = state_q;
    assign in_obj  = in_obj_q;
    assign paint_r = rgb_q[23:16];
    assign paint_g = rgb_q[15:8];
    assign paint_b = rgb_q[7:0];

endmodule
`default_nettype wire
